fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_unit_pcselect_mux.sv | 31 +++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [31:0] pcplus4;
        logic        exception_instr;
        logic        valid;
    } fetch_data_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_pcselect_mux.sv
// Next-PC selection: redirect > jr > jump > taken branch > sequential.
module pcselect_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        is_jr,
    input  logic [31:0] pcjr,
    input  logic        is_jump,
    input  logic [31:0] pcjump,
    input  logic        branch_taken,
    input  logic [31:0] pcbranch,
    output logic [31:0] next_pc
);

    // Fixed-priority select of the next fetch address.
    always_comb begin
        next_pc = pc_plus4(pc);
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (is_jr) begin
            next_pc = pcjr;
        end else if (is_jump) begin
            next_pc = pcjump;
        end else if (branch_taken) begin
            next_pc = pcbranch;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request at a time, fetched word
// held in dataF for decode.
//
// state  | meaning
// IDLE   | PC settled; misaligned PC loads an exception, else start a request
// REQ    | ireq_valid high with ireq_addr = PC until the memory accepts it
// WAIT   | request accepted, waiting for the returned word
// HOLD   | dataF loaded, decode stalled; PC and dataF frozen
// DROP   | fetch killed after acceptance; swallow the next returned word
module fetch_unit #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stallF,
    input  logic        flushF,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        is_jump,
    input  logic        is_jr,
    input  logic        branch_taken,
    input  logic [31:0] pcjump,
    input  logic [31:0] pcjr,
    input  logic [31:0] pcbranch,
    output logic        dataF_valid,
    output logic [31:0] dataF_raw_instr,
    output logic [31:0] dataF_pcplus4,
    output logic        dataF_exception_instr,
    output logic        fetch_busy
);

    import fetch_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_next;
    fetch_data_t  data_q;
    logic         kill;
    logic         pc_load;
    logic         cap_mem;
    logic         cap_exc;
    logic         pc_misaligned;

    // A flush is raised when decode resolves control flow, so the PC is
    // reloaded from the mux on a flush as well as on a redirect.
    assign kill          = redirect_valid | flushF;
    assign pc_misaligned = |pc_q[1:0];

    pcselect_mux u_pcselect (
        .pc             (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .is_jr          (is_jr),
        .pcjr           (pcjr),
        .is_jump        (is_jump),
        .pcjump         (pcjump),
        .branch_taken   (branch_taken),
        .pcbranch       (pcbranch),
        .next_pc        (pc_next)
    );

    // Next-state, PC-load and dataF-capture decisions.
    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        cap_mem = 1'b0;
        cap_exc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kill) begin
                    pc_load = 1'b1;
                end else if (pc_misaligned) begin
                    cap_exc = 1'b1;
                    if (stallF) begin
                        state_d = S_HOLD;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ireq_addr_ok) begin
                    if (kill) begin
                        pc_load = 1'b1;
                        state_d = iresp_data_ok ? S_IDLE : S_DROP;
                    end else if (iresp_data_ok) begin
                        cap_mem = 1'b1;
                        if (stallF) begin
                            state_d = S_HOLD;
                        end else begin
                            pc_load = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (kill) begin
                    pc_load = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (kill) begin
                    pc_load = 1'b1;
                    state_d = iresp_data_ok ? S_IDLE : S_DROP;
                end else if (iresp_data_ok) begin
                    cap_mem = 1'b1;
                    if (stallF) begin
                        state_d = S_HOLD;
                    end else begin
                        pc_load = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (kill || !stallF) begin
                    pc_load = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                pc_load = kill;
                if (iresp_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q <= RESET_PC;
        end else if (pc_load) begin
            pc_q <= pc_next;
        end
    end

    // dataF register: loaded from memory or with an address exception,
    // invalidated on flush/redirect, otherwise held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
        end else if (cap_mem) begin
            data_q.raw_instr       <= iresp_data;
            data_q.pcplus4         <= pc_plus4(pc_q);
            data_q.exception_instr <= 1'b0;
            data_q.valid           <= 1'b1;
        end else if (cap_exc) begin
            data_q.raw_instr       <= 32'd0;
            data_q.pcplus4         <= pc_plus4(pc_q);
            data_q.exception_instr <= 1'b1;
            data_q.valid           <= 1'b1;
        end else if (kill) begin
            data_q.valid <= 1'b0;
        end
    end

    assign ireq_valid            = (state_q == S_REQ);
    assign ireq_addr             = pc_q;
    assign fetch_busy            = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DROP);
    assign dataF_valid           = data_q.valid;
    assign dataF_raw_instr       = data_q.raw_instr;
    assign dataF_pcplus4         = data_q.pcplus4;
    assign dataF_exception_instr = data_q.exception_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected dataF loads.
module tb_fetch_unit;

    import fetch_pkg::*;

    logic        clk;
    logic        resetn;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stallF;
    logic        flushF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        is_jump;
    logic        is_jr;
    logic        branch_taken;
    logic [31:0] pcjump;
    logic [31:0] pcjr;
    logic [31:0] pcbranch;
    logic        dataF_valid;
    logic [31:0] dataF_raw_instr;
    logic [31:0] dataF_pcplus4;
    logic        dataF_exception_instr;
    logic        fetch_busy;

    int passed = 0;
    int total  = 0;
    fetch_data_t exp_q[$];

    fetch_unit dut (
        .clk                   (clk),
        .resetn                (resetn),
        .ireq_valid            (ireq_valid),
        .ireq_addr             (ireq_addr),
        .ireq_addr_ok          (ireq_addr_ok),
        .iresp_data_ok         (iresp_data_ok),
        .iresp_data            (iresp_data),
        .stallF                (stallF),
        .flushF                (flushF),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .is_jump               (is_jump),
        .is_jr                 (is_jr),
        .branch_taken          (branch_taken),
        .pcjump                (pcjump),
        .pcjr                  (pcjr),
        .pcbranch              (pcbranch),
        .dataF_valid           (dataF_valid),
        .dataF_raw_instr       (dataF_raw_instr),
        .dataF_pcplus4         (dataF_pcplus4),
        .dataF_exception_instr (dataF_exception_instr),
        .fetch_busy            (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq_addr_ok   = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'd0;
        stallF         = 1'b0;
        flushF         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        is_jump        = 1'b0;
        is_jr          = 1'b0;
        branch_taken   = 1'b0;
        pcjump         = 32'd0;
        pcjr           = 32'd0;
        pcbranch       = 32'd0;
    endtask

    task automatic push_exp(input logic [31:0] raw, input logic [31:0] pcp4, input logic exc);
        fetch_data_t e;
        e.raw_instr       = raw;
        e.pcplus4         = pcp4;
        e.exception_instr = exc;
        e.valid           = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check_load(input string tag);
        fetch_data_t e;
        total++;
        assert (exp_q.size() > 0) passed++;
        else $error("FAIL %s_sb observed=empty expected=entry", tag);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, {31'd0, dataF_valid}, {31'd0, e.valid});
            chk({tag, "_raw"}, dataF_raw_instr, e.raw_instr);
            chk({tag, "_pcp4"}, dataF_pcplus4, e.pcplus4);
            chk({tag, "_exc"}, {31'd0, dataF_exception_instr}, {31'd0, e.exception_instr});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ireq_valid"}, {31'd0, ireq_valid}, 32'd0);
        chk({tag, "_valid"}, {31'd0, dataF_valid}, 32'd0);
        chk({tag, "_raw"}, dataF_raw_instr, 32'd0);
        chk({tag, "_pcp4"}, dataF_pcplus4, 32'd0);
        chk({tag, "_exc"}, {31'd0, dataF_exception_instr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, fetch_busy}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 resetn = 1'b1;

        // Basic fetch at the reset vector, decode stalled on return.
        step();
        chk("first_req_valid", {31'd0, ireq_valid}, 32'd1);
        chk("first_req_addr", ireq_addr, 32'hBFC0_0000);
        chk("first_req_busy", {31'd0, fetch_busy}, 32'd1);
        ireq_addr_ok = 1'b1;
        step();
        chk("wait_req_low", {31'd0, ireq_valid}, 32'd0);
        chk("wait_valid_low", {31'd0, dataF_valid}, 32'd0);
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h2402_0001;
        stallF        = 1'b1;
        push_exp(32'h2402_0001, 32'hBFC0_0004, 1'b0);
        step();
        check_load("first_load");
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;

        // Four stalled cycles: everything frozen.
        for (int i = 0; i < 4; i++) begin
            chk("hold_busy", {31'd0, fetch_busy}, 32'd0);
            chk("hold_req", {31'd0, ireq_valid}, 32'd0);
            chk("hold_pc", ireq_addr, 32'hBFC0_0000);
            chk("hold_raw", dataF_raw_instr, 32'h2402_0001);
            chk("hold_valid", {31'd0, dataF_valid}, 32'd1);
            step();
        end

        // Release with jr and a taken branch together: jr wins.
        stallF       = 1'b0;
        is_jr        = 1'b1;
        pcjr         = 32'h8000_0100;
        branch_taken = 1'b1;
        pcbranch     = 32'h8000_0AA0;
        step();
        clear_inputs();
        chk("jr_idle_req", {31'd0, ireq_valid}, 32'd0);
        step();
        chk("jr_req_addr", ireq_addr, 32'h8000_0100);

        // Request held stable without acceptance.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("req_stable_valid", {31'd0, ireq_valid}, 32'd1);
            chk("req_stable_addr", ireq_addr, 32'h8000_0100);
        end

        // Acceptance and data in the same cycle.
        ireq_addr_ok  = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h3C01_1234;
        push_exp(32'h3C01_1234, 32'h8000_0104, 1'b0);
        step();
        check_load("same_cycle_load");
        clear_inputs();
        step();
        chk("seq_req_addr", ireq_addr, 32'h8000_0104);
        ireq_addr_ok = 1'b1;
        step();

        // Flush in WAIT with a taken branch; stale word must be dropped.
        clear_inputs();
        flushF       = 1'b1;
        branch_taken = 1'b1;
        pcbranch     = 32'h8000_0200;
        step();
        chk("drop_valid", {31'd0, dataF_valid}, 32'd0);
        chk("drop_busy", {31'd0, fetch_busy}, 32'd1);
        clear_inputs();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        chk("stale_valid", {31'd0, dataF_valid}, 32'd0);
        chk("stale_raw", dataF_raw_instr, 32'h3C01_1234);
        chk("stale_busy", {31'd0, fetch_busy}, 32'd0);
        step();
        chk("post_flush_addr", ireq_addr, 32'h8000_0200);
        chk("post_flush_req", {31'd0, ireq_valid}, 32'd1);
        ireq_addr_ok = 1'b1;
        step();
        clear_inputs();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h8C22_0008;
        push_exp(32'h8C22_0008, 32'h8000_0204, 1'b0);
        step();
        check_load("post_flush_load");

        // Redirect to a misaligned PC: exception load, no request.
        clear_inputs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0182;
        step();
        clear_inputs();
        chk("redir_valid", {31'd0, dataF_valid}, 32'd0);
        chk("redir_req", {31'd0, ireq_valid}, 32'd0);
        stallF = 1'b1;
        push_exp(32'h0, 32'h8000_0186, 1'b1);
        step();
        check_load("exc_load");
        for (int i = 0; i < 2; i++) begin
            chk("exc_no_req", {31'd0, ireq_valid}, 32'd0);
            chk("exc_busy", {31'd0, fetch_busy}, 32'd0);
            step();
        end

        // Redirect overrides the stall.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        clear_inputs();
        chk("redir_stall_valid", {31'd0, dataF_valid}, 32'd0);
        step();
        chk("redir_stall_addr", ireq_addr, 32'h8000_0300);

        // Flush before acceptance withdraws the request.
        flushF       = 1'b1;
        branch_taken = 1'b1;
        pcbranch     = 32'h8000_0400;
        step();
        clear_inputs();
        chk("withdraw_req", {31'd0, ireq_valid}, 32'd0);
        chk("withdraw_busy", {31'd0, fetch_busy}, 32'd0);
        step();
        chk("withdraw_addr", ireq_addr, 32'h8000_0400);

        // Jump beats a taken branch.
        ireq_addr_ok = 1'b1;
        step();
        clear_inputs();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0800_0140;
        is_jump       = 1'b1;
        pcjump        = 32'h8000_0500;
        branch_taken  = 1'b1;
        pcbranch      = 32'h8000_0600;
        push_exp(32'h0800_0140, 32'h8000_0404, 1'b0);
        step();
        check_load("jump_load");
        clear_inputs();
        step();
        chk("jump_addr", ireq_addr, 32'h8000_0500);

        // Redirect beats jr while waiting; then reset abandons the fetch.
        ireq_addr_ok = 1'b1;
        step();
        clear_inputs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0700;
        is_jr          = 1'b1;
        pcjr           = 32'h8000_0800;
        step();
        clear_inputs();
        chk("redir_wait_busy", {31'd0, fetch_busy}, 32'd1);
        chk("redir_wait_pc", ireq_addr, 32'h8000_0700);
        resetn = 1'b0;
        #2;
        check_reset_outputs("midrun_reset");
        chk("midrun_reset_pc", ireq_addr, 32'hBFC0_0000);
        @(posedge clk);
        #1 resetn = 1'b1;
        step();
        chk("after_reset_req", {31'd0, ireq_valid}, 32'd1);
        chk("after_reset_addr", ireq_addr, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
